// File: rtl/axis_image_framer_pkg.sv
// Shared types and defaults for the AXI-Stream image framer.
// Holds the framer state encoding and default image geometry.
package axis_image_framer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W      = 28;
  localparam int DEF_IMG_H      = 28;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Index width for a counter over 0..n-1, at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry registered AXI-Stream output stage carrying data, last and user.
module axis_out_reg
  import axis_image_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_user,
  output logic                  out_valid,
  input  logic                  out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat whenever the slot is free or being drained; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_user  <= in_user;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_image_framer.sv
// Forces an upstream pixel stream into fixed IMG_W x IMG_H frames: short
// frames are zero-padded, long frames are truncated until their tlast.
module axis_image_framer
  import axis_image_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_short_frame,
  output logic                  status_long_frame,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int COL_W = idx_width(IMG_W);
  localparam int ROW_W = idx_width(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t                  state, state_nxt;
  logic [COL_W-1:0]        col, col_nxt;
  logic [ROW_W-1:0]        row, row_nxt;
  logic                    out_ready;
  logic                    emit_valid;
  logic [DATA_WIDTH-1:0]   emit_data;
  logic                    advance;
  logic                    ready_int;
  logic                    short_nxt, long_nxt;
  logic                    at_first, at_final;

  assign at_first      = (row == {ROW_W{1'b0}}) && (col == {COL_W{1'b0}});
  assign at_final      = (row == ROW_LAST) && (col == COL_LAST);
  assign s_axis_tready = rst_n && ready_int;

  // Next-state, emit and position logic.
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    emit_valid = 1'b0;
    emit_data  = '0;
    advance    = 1'b0;
    ready_int  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      ST_PASS: begin
        ready_int = out_ready;
        if (s_axis_tvalid && out_ready) begin
          emit_valid = 1'b1;
          emit_data  = s_axis_tdata;
          advance    = 1'b1;
          if (at_final && !s_axis_tlast) begin
            long_nxt  = 1'b1;
            state_nxt = ST_DROP;
          end else if (!at_final && s_axis_tlast) begin
            short_nxt = 1'b1;
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_PASS;
          end
        end else begin
          state_nxt = ST_PASS;
        end
      end
      ST_PAD: begin
        if (out_ready) begin
          emit_valid = 1'b1;
          advance    = 1'b1;
          state_nxt  = at_final ? ST_PASS : ST_PAD;
        end else begin
          state_nxt = ST_PAD;
        end
      end
      ST_DROP: begin
        // Position already wrapped to (0,0) when the final pixel went out.
        ready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = ST_PASS;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      default: begin
        state_nxt = ST_PASS;
      end
    endcase

    if (advance) begin
      if (col == COL_LAST) begin
        col_nxt = {COL_W{1'b0}};
        if (row == ROW_LAST) begin
          row_nxt = {ROW_W{1'b0}};
        end else begin
          row_nxt = row + ROW_W'(1);
        end
      end else begin
        col_nxt = col + COL_W'(1);
        row_nxt = row;
      end
    end else begin
      col_nxt = col;
      row_nxt = row;
    end
  end

  // State, position, status pulses and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_PASS;
      col                <= {COL_W{1'b0}};
      row                <= {ROW_W{1'b0}};
      status_short_frame <= 1'b0;
      status_long_frame  <= 1'b0;
      frame_count        <= {CNT_WIDTH{1'b0}};
    end else begin
      state              <= state_nxt;
      col                <= col_nxt;
      row                <= row_nxt;
      status_short_frame <= short_nxt;
      status_long_frame  <= long_nxt;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (emit_data),
    .in_last   (at_final),
    .in_user   (at_first),
    .in_valid  (emit_valid),
    .in_ready  (out_ready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_user  (m_axis_tuser),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_image_framer.sv
// Self-checking bench for axis_image_framer with a 4x2 image and a 3-bit frame counter.
module tb_axis_image_framer;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CW   = 3;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last, m_user;
  logic          st_short, st_long;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  axis_image_framer #(
    .DATA_WIDTH (DW), .IMG_W (W), .IMG_H (H), .CNT_WIDTH (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_tdata       (s_data),
    .s_axis_tvalid      (s_valid),
    .s_axis_tready      (s_ready),
    .s_axis_tlast       (s_last),
    .m_axis_tdata       (m_data),
    .m_axis_tvalid      (m_valid),
    .m_axis_tready      (m_ready),
    .m_axis_tlast       (m_last),
    .m_axis_tuser       (m_user),
    .status_short_frame (st_short),
    .status_long_frame  (st_long),
    .frame_count        (frame_count)
  );

  int checks = 0;
  int failures = 0;
  beat_t exp_q[$];
  logic [DW-1:0] pkt[$];
  int exp_short = 0, exp_long = 0, exp_frames = 0;
  int obs_short = 0, obs_long = 0, stab_err = 0, width_err = 0, in_stall = 0;
  int rdy_mode = 0;
  int gap_max = 0;
  bit sb_ignore = 1'b0;

  // Output ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = !m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard and protocol monitor sampling on the falling edge.
  initial begin
    bit prev_stall = 1'b0, prev_short = 1'b0, prev_long = 1'b0;
    beat_t pv, e;
    pv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; prev_short = 1'b0; prev_long = 1'b0;
      end else begin
        if (s_valid && !s_ready) in_stall++;
        if (prev_stall && (m_valid !== 1'b1 || {m_data, m_last, m_user} !== pv)) stab_err++;
        prev_stall = m_valid && !m_ready;
        pv = {m_data, m_last, m_user};
        if (m_valid && m_ready && !sb_ignore) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_extra: got data=%02h last=%0b user=%0b, expected no beat",
                     m_data, m_last, m_user);
          end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last, m_user} !== e) begin
              failures++;
              $display("FAIL scoreboard_beat: got data=%02h last=%0b user=%0b, expected data=%02h last=%0b user=%0b",
                       m_data, m_last, m_user, e.data, e.last, e.user);
            end
          end
        end
        if (st_short) begin if (prev_short) width_err++; else obs_short++; end
        if (st_long)  begin if (prev_long)  width_err++; else obs_long++;  end
        prev_short = st_short;
        prev_long  = st_long;
      end
    end
  end

  // Reference: every input packet becomes exactly one NPIX-pixel frame.
  task automatic model_packet();
    int len = pkt.size();
    for (int i = 0; i < NPIX; i++) begin
      beat_t b;
      b.data = (i < len) ? pkt[i] : 8'h00;
      b.last = (i == NPIX - 1);
      b.user = (i == 0);
      exp_q.push_back(b);
    end
    if (len < NPIX) exp_short++;
    else if (len > NPIX) exp_long++;
    exp_frames++;
  endtask

  // Must be called just after a rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bit ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      n++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL input_timeout: tready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
  endtask

  task automatic drive_packet();
    for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %0b, expected 0", s_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_data, m_last, m_user, st_short, st_long} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b data=%02h last=%0b user=%0b short=%0b long=%0b, expected all 0",
               m_valid, m_data, m_last, m_user, st_short, st_long);
    end
    checks++;
    if (frame_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d, expected 0", frame_count); end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_tready: got %0b, expected 1", s_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    int s0 = obs_short, l0 = obs_long;
    rdy_mode = 0; gap_max = 0;
    pkt.delete();
    for (int i = 0; i < NPIX; i++) pkt.push_back(8'(8'h10 + i));
    model_packet();
    for (int i = 0; i < NPIX; i++) begin
      send_beat(pkt[i], i == NPIX - 1);
      if (i == 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h10 || m_user !== 1'b1) begin
          failures++;
          $display("FAIL good_latency: got valid=%0b data=%02h user=%0b, expected 1 10 1", m_valid, m_data, m_user);
        end
      end
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL good_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (frame_count !== 3'(exp_frames % 8)) begin
      failures++; $display("FAIL good_count: got %0d, expected %0d", frame_count, exp_frames % 8);
    end
    checks++;
    if (obs_short != s0 || obs_long != l0) begin
      failures++; $display("FAIL good_status: got short=%0d long=%0d pulses, expected 0 0", obs_short - s0, obs_long - l0);
    end
  endtask

  task automatic test_short_frame();
    int s0 = obs_short;
    logic [3:0] tr, ss;
    rdy_mode = 0; gap_max = 0;
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(8'(8'h20 + i));
    model_packet();
    drive_packet();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tr[k] = s_ready;
      ss[k] = st_short;
    end
    checks++;
    if (tr !== 4'b1000) begin failures++; $display("FAIL short_pad_tready: got %b, expected 1000", tr); end
    checks++;
    if (ss !== 4'b0001) begin failures++; $display("FAIL short_pulse_timing: got %b, expected 0001", ss); end
    @(posedge clk);
    #1;
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL short_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (obs_short - s0 != 1) begin failures++; $display("FAIL short_pulses: got %0d, expected 1", obs_short - s0); end
  endtask

  task automatic test_long_frame();
    int l0 = obs_long;
    rdy_mode = 0; gap_max = 0;
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h30 + i));
    model_packet();
    drive_packet();
    pkt.delete();
    for (int i = 0; i < NPIX; i++) pkt.push_back(8'(8'h40 + i));
    model_packet();
    drive_packet();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL long_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (obs_long - l0 != 1) begin failures++; $display("FAIL long_pulses: got %0d, expected 1", obs_long - l0); end
    checks++;
    if (frame_count !== 3'(exp_frames % 8)) begin
      failures++; $display("FAIL long_count: got %0d, expected %0d", frame_count, exp_frames % 8);
    end
  endtask

  task automatic test_back_to_back();
    int st0 = stab_err, is0;
    rdy_mode = 1; gap_max = 0;
    for (int f = 0; f < 2; f++) begin
      pkt.delete();
      for (int i = 0; i < NPIX; i++) pkt.push_back(8'($urandom));
      model_packet();
      drive_packet();
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (stab_err != st0) begin failures++; $display("FAIL b2b_stall_stability: got %0d violations, expected 0", stab_err - st0); end
    checks++;
    if (frame_count !== 3'(exp_frames % 8)) begin
      failures++; $display("FAIL b2b_count: got %0d, expected %0d", frame_count, exp_frames % 8);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    is0 = in_stall;
    for (int f = 0; f < 3; f++) begin
      pkt.delete();
      for (int i = 0; i < NPIX; i++) pkt.push_back(8'($urandom));
      model_packet();
      drive_packet();
    end
    checks++;
    if (in_stall != is0) begin failures++; $display("FAIL throughput_bubbles: got %0d stall cycles, expected 0", in_stall - is0); end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL throughput_drain: %0d beats missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int s0 = obs_short, l0 = obs_long, es0 = exp_short, el0 = exp_long, st0 = stab_err;
    rdy_mode = 2; gap_max = 2;
    for (int p = 0; p < 14; p++) begin
      int len = ($urandom_range(0, 2) == 0) ? NPIX : $urandom_range(1, 12);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      model_packet();
      drive_packet();
    end
    wait_drain();
    rdy_mode = 0; gap_max = 0;
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL random_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (obs_short - s0 != exp_short - es0) begin
      failures++; $display("FAIL random_short: got %0d pulses, expected %0d", obs_short - s0, exp_short - es0);
    end
    checks++;
    if (obs_long - l0 != exp_long - el0) begin
      failures++; $display("FAIL random_long: got %0d pulses, expected %0d", obs_long - l0, exp_long - el0);
    end
    checks++;
    if (stab_err != st0 || width_err != 0) begin
      failures++; $display("FAIL random_protocol: got %0d stall and %0d width violations, expected 0 0", stab_err - st0, width_err);
    end
    checks++;
    if (frame_count !== 3'(exp_frames % 8)) begin
      failures++; $display("FAIL random_count: got %0d, expected %0d", frame_count, exp_frames % 8);
    end
  endtask

  task automatic test_reset_mid_frame();
    rdy_mode = 0; gap_max = 0;
    sb_ignore = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h50 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== 3'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: got valid=%0b count=%0d tready=%0b, expected 0 0 0", m_valid, frame_count, s_ready);
    end
    exp_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_ignore = 1'b0;
    @(posedge clk);
    #1;
    pkt.delete();
    for (int i = 0; i < NPIX; i++) pkt.push_back(8'(8'h60 + i));
    model_packet();
    drive_packet();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_drain: %0d beats missing, expected 0", exp_q.size()); end
    checks++;
    if (frame_count !== 3'd1) begin failures++; $display("FAIL midreset_count: got %0d, expected 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_image_framer.md
AXIS_IMAGE_FRAMER -- requirements
Module: axis_image_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 28, pixels per row (min 2).
REQ-003 SHALL have parameter IMG_H, default 28, rows per frame (min 1).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of frame_count.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_axis_tdata  input  DATA_WIDTH  pixel from upstream FIFO.
REQ-008 SHALL have ports s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1: upstream handshake and end-of-image marker.
REQ-009 SHALL have port m_axis_tdata  output  DATA_WIDTH  pixel to CNN input stage.
REQ-010 SHALL have ports m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: last pixel of frame.
REQ-011 SHALL have port m_axis_tuser  output  1  start of frame, high on pixel (0,0) only.
REQ-012 SHALL have ports status_short_frame, status_long_frame  output  1  one-cycle pulses.
REQ-013 SHALL have port frame_count  output  CNT_WIDTH  number of frames emitted.

Function
REQ-014 SHALL register all m_axis outputs in a one-entry output stage; out_ready = !m_axis_tvalid || m_axis_tready; accepted beat appears on m_axis after exactly 1 cycle.
REQ-015 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) of the next emitted pixel; col wraps to 0 and row increments at col==IMG_W-1; both clear after the frame-final pixel.
REQ-016 SHALL tag each emitted beat: tuser = (row==0 && col==0); tlast = (row==IMG_H-1 && col==IMG_W-1).
REQ-017 SHALL implement states PASS, PAD, DROP; reset state PASS.
REQ-018 PASS: s_axis_tready = out_ready; each accepted beat emitted with its tdata and counters advance.
REQ-019 PASS, accepted beat at frame-final position with s_axis_tlast=1: emit with tlast, stay PASS.
REQ-020 PASS, accepted beat at frame-final position with s_axis_tlast=0: emit with tlast, pulse status_long_frame, go DROP.
REQ-021 PASS, accepted beat not at final position with s_axis_tlast=1: emit it (tlast=0), pulse status_short_frame, go PAD.
REQ-022 PAD: s_axis_tready=0; whenever out_ready, emit tdata=0 and advance; on emitting the final position, assert tlast and go PASS.
REQ-023 DROP: s_axis_tready=1; discard beats, nothing emitted; accepted beat with s_axis_tlast=1 returns to PASS with counters at (0,0).
REQ-024 SHALL never deassert m_axis_tvalid or change m_axis_t* while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 SHALL increment frame_count on each transferred beat with m_axis_tlast=1, wrapping modulo 2^CNT_WIDTH.
REQ-026 Back-to-back input and output with tready=1 SHALL sustain one pixel per cycle with no bubble, including across frame boundaries.
REQ-027 Status pulses SHALL last exactly one cycle, asserted the cycle after the triggering input beat.

Reset
REQ-028 rst_n=0 SHALL immediately clear: state=PASS, col=row=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, status pulses=0, frame_count=0.
REQ-029 s_axis_tready SHALL be 0 while rst_n=0; reset mid-frame discards partial frame, next accepted pixel is (0,0).
REQ-030 Deassertion SHALL be synchronised externally; block behaves correctly from the first rising edge after release.

Structure
REQ-031 Shared package SHALL hold the state enumeration and default IMG_W/IMG_H/DATA_WIDTH constants.
REQ-032 Output stage SHALL be a sub-module axis_out_reg (data+last+user, valid/ready, async active-low reset).

Verification (IMG_W=4, IMG_H=2, DATA_WIDTH=8)
REQ-033 8 beats 0x10..0x17, tlast on 8th, ready=1 -> same 8 beats out, tuser on 0x10, tlast on 0x17, frame_count=1, no status pulse.
REQ-034 5 beats 0x20..0x24, tlast on 5th -> out 0x20..0x24 then 0x00,0x00,0x00 with tlast on last; status_short_frame one pulse; s_axis_tready=0 for 3 pad cycles.
REQ-035 10 beats, tlast on 10th -> first 8 emitted, tlast on 8th, beats 9-10 dropped, status_long_frame pulse; next frame starts with tuser=1.
REQ-036 Two good frames back-to-back, m_axis_tready toggling 1/0 each cycle -> all 16 pixels in order, outputs stable while stalled, frame_count=2.
REQ-037 rst_n pulsed low after 3 beats of a frame -> m_axis_tvalid=0 at once, frame_count=0; following 8-beat frame emitted intact with tuser on its first pixel.
